// File: rtl/mem_drv_pkg.sv
// Shared encodings for the memory request driver: targets, status codes, FSM states.
package mem_drv_pkg;

  typedef enum logic [1:0] {
    TGT_SDRAM = 2'd0,
    TGT_FLASH = 2'd1,
    TGT_ROM   = 2'd2,
    TGT_RSVD  = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ABORT   = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BADTGT  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_RDY = 3'd1,
    S_BEAT     = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  // Coverage index is {state, target, out_valid}
  localparam int COV_W = 6;

  // A beat count of zero means a full three-beat burst
  function automatic logic [1:0] norm_beats(input logic [1:0] b);
    return (b == 2'd0) ? 2'd3 : b;
  endfunction

endpackage

// File: rtl/mem_drv_covmap.sv
// State-coverage map: one bit per index, plus a saturating count of distinct hits.
module mem_drv_covmap
  import mem_drv_pkg::*;
(
  input  logic             clock,
  input  logic             i_meta_reset,
  input  logic [COV_W-1:0] i_idx,
  output logic [COV_W-1:0] o_count
);

  logic [(1<<COV_W)-1:0] r_map;
  logic [COV_W-1:0]      r_count;

  // First visit of an index marks it and bumps the count; meta_reset wins
  always_ff @(posedge clock) begin
    if (i_meta_reset) begin
      r_map   <= '0;
      r_count <= '0;
    end else if (!r_map[i_idx]) begin
      r_map[i_idx] <= 1'b1;
      if (r_count != '1) r_count <= r_count + COV_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_req_driver.sv
// Serialises one command onto the SDRAM/FLASH/ROM channel, waits for the
// controller response and hands a status back upstream.
module mem_req_driver
  import mem_drv_pkg::*;
#(
  parameter int RDY_TIMEOUT = 16,
  parameter int RSP_TIMEOUT = 4,
  parameter int TO_W        = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_meta_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_target,
  input  logic [3:0] i_cmd_data,
  input  logic [1:0] i_cmd_beats,
  output logic       o_sdram_valid,
  output logic [1:0] o_sdram_data_o,
  output logic       o_flash_valid,
  output logic [3:0] o_flash_data_o,
  output logic       o_rom_valid,
  output logic       o_rom_data_o,
  input  logic       i_sdram_ready,
  input  logic       i_flash_ready,
  input  logic       i_rom_ready,
  input  logic       i_out_valid,
  input  logic [3:0] i_out_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [3:0] o_rsp_data,
  output logic [1:0] o_rsp_status,
  output logic [5:0] o_coverage
);

  state_e          r_state, w_nxt_state;
  tgt_e            r_tgt;
  logic [3:0]      r_data;
  logic [1:0]      r_beats;
  logic [1:0]      r_beat_cnt, w_nxt_beat;
  logic [TO_W-1:0] r_timer, w_nxt_timer;
  logic [3:0]      r_rsp_data, w_nxt_rsp_data;
  status_e         r_rsp_status, w_nxt_status;
  logic            w_latch, w_sel_ready;

  logic            w_sdram_v, w_flash_v, w_rom_v, w_rom_d;
  logic [1:0]      w_sdram_d;
  logic [3:0]      w_flash_d;
  logic [COV_W-1:0] w_cov_idx;

  // Ready of the latched target channel
  always_comb begin
    w_sel_ready = 1'b0;
    case (r_tgt)
      TGT_SDRAM: w_sel_ready = i_sdram_ready;
      TGT_FLASH: w_sel_ready = i_flash_ready;
      TGT_ROM:   w_sel_ready = i_rom_ready;
      default:   w_sel_ready = 1'b0;
    endcase
  end

  // Next-state, beat counter, timer and response selection
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_beat     = r_beat_cnt;
    w_nxt_timer    = r_timer;
    w_nxt_rsp_data = r_rsp_data;
    w_nxt_status   = r_rsp_status;
    w_latch        = 1'b0;
    case (r_state)
      S_IDLE: if (i_cmd_valid) begin
        w_latch = 1'b1;
        if (i_cmd_target == TGT_RSVD) begin
          w_nxt_state    = S_RESP;
          w_nxt_status   = ST_BADTGT;
          w_nxt_rsp_data = 4'h0;
        end else begin
          w_nxt_state = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (w_sel_ready) begin
          w_nxt_state = S_BEAT;
          w_nxt_beat  = 2'd0;
        end else if (r_timer == TO_W'(RDY_TIMEOUT - 1)) begin
          w_nxt_state    = S_RESP;
          w_nxt_status   = ST_TIMEOUT;
          w_nxt_rsp_data = 4'h0;
        end else begin
          w_nxt_timer = r_timer + TO_W'(1);
        end
      end
      S_BEAT: begin
        if (r_beat_cnt == r_beats - 2'd1) begin
          if (r_beats == 2'd3) begin
            w_nxt_state = S_WAIT_RSP;
          end else begin
            w_nxt_state    = S_RESP;
            w_nxt_status   = ST_ABORT;
            w_nxt_rsp_data = 4'h0;
          end
        end else begin
          w_nxt_beat = r_beat_cnt + 2'd1;
        end
      end
      S_WAIT_RSP: begin
        if (i_out_valid) begin
          w_nxt_state    = S_RESP;
          w_nxt_status   = ST_OK;
          w_nxt_rsp_data = (r_tgt == TGT_ROM) ? 4'h0 : i_out_data;
        end else if (r_timer == TO_W'(RSP_TIMEOUT - 1)) begin
          w_nxt_state    = S_RESP;
          w_nxt_status   = ST_TIMEOUT;
          w_nxt_rsp_data = 4'h0;
        end else begin
          w_nxt_timer = r_timer + TO_W'(1);
        end
      end
      S_RESP: if (i_rsp_ready) w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
    // Every state entry starts its timer from zero
    if (w_nxt_state != r_state) w_nxt_timer = '0;
  end

  // Channel outputs for the upcoming cycle, registered below
  always_comb begin
    w_sdram_v = 1'b0;
    w_sdram_d = 2'b00;
    w_flash_v = 1'b0;
    w_flash_d = 4'h0;
    w_rom_v   = 1'b0;
    w_rom_d   = 1'b0;
    if (w_nxt_state == S_BEAT) begin
      case (r_tgt)
        TGT_SDRAM: begin
          w_sdram_v = 1'b1;
          case (w_nxt_beat)
            2'd0:    w_sdram_d = r_data[1:0];
            2'd1:    w_sdram_d = r_data[3:2];
            default: w_sdram_d = 2'b00;
          endcase
        end
        TGT_FLASH: begin
          w_flash_v = 1'b1;
          w_flash_d = r_data;
        end
        TGT_ROM: begin
          w_rom_v = 1'b1;
          w_rom_d = r_data[w_nxt_beat];
        end
        default: ;
      endcase
    end
  end

  // FSM and command/response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tgt        <= TGT_SDRAM;
      r_data       <= 4'h0;
      r_beats      <= 2'd0;
      r_beat_cnt   <= 2'd0;
      r_timer      <= '0;
      r_rsp_data   <= 4'h0;
      r_rsp_status <= ST_OK;
    end else begin
      r_state      <= w_nxt_state;
      r_beat_cnt   <= w_nxt_beat;
      r_timer      <= w_nxt_timer;
      r_rsp_data   <= w_nxt_rsp_data;
      r_rsp_status <= w_nxt_status;
      if (w_latch) begin
        r_tgt   <= tgt_e'(i_cmd_target);
        r_data  <= i_cmd_data;
        r_beats <= norm_beats(i_cmd_beats);
      end
    end
  end

  // Registered channel valids and data
  always_ff @(posedge clock) begin
    if (reset) begin
      o_sdram_valid  <= 1'b0;
      o_sdram_data_o <= 2'b00;
      o_flash_valid  <= 1'b0;
      o_flash_data_o <= 4'h0;
      o_rom_valid    <= 1'b0;
      o_rom_data_o   <= 1'b0;
    end else begin
      o_sdram_valid  <= w_sdram_v;
      o_sdram_data_o <= w_sdram_d;
      o_flash_valid  <= w_flash_v;
      o_flash_data_o <= w_flash_d;
      o_rom_valid    <= w_rom_v;
      o_rom_data_o   <= w_rom_d;
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_rsp_valid  = (r_state == S_RESP);
  assign o_rsp_data   = r_rsp_data;
  assign o_rsp_status = r_rsp_status;

  assign w_cov_idx = {r_state, r_tgt, i_out_valid};

  mem_drv_covmap u_covmap (
    .clock        (clock),
    .i_meta_reset (i_meta_reset),
    .i_idx        (w_cov_idx),
    .o_count      (o_coverage)
  );

endmodule

// File: tb/tb_mem_req_driver.sv
// Scoreboard bench: the driver pushes expected beats/responses derived from the
// transaction rules; a negedge monitor pops and compares whatever the DUT emits.
module tb_mem_req_driver;

  typedef struct { logic [9:0] vec; int cyc; } beat_t;
  typedef struct { logic [1:0] st; logic [3:0] data; int cyc; } rsp_t;

  logic clock = 0, reset = 1, meta_reset = 1;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_target = 0, cmd_beats = 0;
  logic [3:0] cmd_data = 0;
  logic sdram_valid, flash_valid, rom_valid, rom_data_o;
  logic [1:0] sdram_data_o;
  logic [3:0] flash_data_o;
  logic sdram_ready = 0, flash_ready = 0, rom_ready = 0;
  logic out_valid = 0, rsp_ready = 0, rsp_valid;
  logic [3:0] out_data = 0, rsp_data;
  logic [1:0] rsp_status;
  logic [5:0] coverage;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit mon_en = 0;
  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  rsp_t  cur_rsp;
  logic  prev_rsp = 0, prev_hs = 0;

  localparam logic [1:0] OK = 2'd0, ABORT = 2'd1, TMO = 2'd2, BADT = 2'd3;

  mem_req_driver dut (
    .clock(clock), .reset(reset), .i_meta_reset(meta_reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_target(cmd_target),
    .i_cmd_data(cmd_data), .i_cmd_beats(cmd_beats),
    .o_sdram_valid(sdram_valid), .o_sdram_data_o(sdram_data_o),
    .o_flash_valid(flash_valid), .o_flash_data_o(flash_data_o),
    .o_rom_valid(rom_valid), .o_rom_data_o(rom_data_o),
    .i_sdram_ready(sdram_ready), .i_flash_ready(flash_ready), .i_rom_ready(rom_ready),
    .i_out_valid(out_valid), .i_out_data(out_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_status(rsp_status), .o_coverage(coverage)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected channel bus {sv,sd[1:0],fv,fd[3:0],rv,rd} for beat k
  function automatic logic [9:0] beat_vec(input logic [1:0] tgt, input logic [3:0] d, input int k);
    logic sv, fv, rv, rd;
    logic [1:0] sd;
    logic [3:0] fd;
    sv = 0; fv = 0; rv = 0; rd = 0; sd = 0; fd = 0;
    case (tgt)
      2'd0: begin sv = 1; sd = (k == 0) ? d[1:0] : (k == 1) ? d[3:2] : 2'b00; end
      2'd1: begin fv = 1; fd = d; end
      2'd2: begin rv = 1; rd = d[k]; end
      default: ;
    endcase
    return {sv, sd, fv, fd, rv, rd};
  endfunction

  // Monitor: compare every emitted beat and every response against the queues
  always @(negedge clock) begin
    beat_t eb;
    rsp_t  er;
    logic [9:0] v;
    v = {sdram_valid, sdram_data_o, flash_valid, flash_data_o, rom_valid, rom_data_o};
    if (mon_en) begin
      if (sdram_valid || flash_valid || rom_valid) begin
        if (beat_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_unexpected: got %h at cycle %0d expected no beat", v, cyc);
        end else begin
          eb = beat_q.pop_front();
          chk("beat_vec", v, eb.vec);
          chk("beat_cycle", cyc, eb.cyc);
        end
      end
      if (prev_hs) chk("rsp_valid_drop", rsp_valid, 0);
      if (rsp_valid) begin
        if (!prev_rsp) begin
          if (rsp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_unexpected: got status %0d at cycle %0d expected none", rsp_status, cyc);
          end else begin
            er = rsp_q.pop_front();
            cur_rsp <= er;
            chk("rsp_status", rsp_status, er.st);
            chk("rsp_data", rsp_data, er.data);
            chk("rsp_cycle", cyc, er.cyc);
          end
        end else begin
          chk("rsp_status_stable", rsp_status, cur_rsp.st);
          chk("rsp_data_stable", rsp_data, cur_rsp.data);
        end
        chk("cmd_ready_in_resp", cmd_ready, 0);
      end
    end
    prev_rsp <= rsp_valid;
    prev_hs  <= rsp_valid && rsp_ready;
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Drive the selected ready to sel, all others to noise
  task automatic set_rdy(input logic [1:0] tgt, input logic sel);
    sdram_ready = (tgt == 0) ? sel : 1'($urandom_range(0, 1));
    flash_ready = (tgt == 1) ? sel : 1'($urandom_range(0, 1));
    rom_ready   = (tgt == 2) ? sel : 1'($urandom_range(0, 1));
  endtask

  task automatic recover();
    reset = 1; tick(); reset = 0;
    beat_q.delete(); rsp_q.delete();
  endtask

  // One transaction: ready after D cycles of WAIT_RDY, out_valid after R cycles
  // of WAIT_RSP, rsp_ready after hold cycles of RESP.
  task automatic run_txn(input logic [1:0] tgt, input logic [3:0] d, input logic [1:0] b,
                         input int D, input int R, input logic [3:0] od, input int hold);
    int n, T, g;
    beat_t eb;
    rsp_t er;
    n = (b == 0) ? 3 : int'(b);
    g = 0;
    while (!cmd_ready && g < 60) begin tick(); g++; end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", cmd_ready, 1);
      recover();
    end
    T = cyc;
    if (tgt == 3) begin
      er = '{BADT, 4'h0, T + 1}; rsp_q.push_back(er);
    end else if (D >= 16) begin
      er = '{TMO, 4'h0, T + 17}; rsp_q.push_back(er);
    end else begin
      for (int k = 0; k < n; k++) begin
        eb = '{beat_vec(tgt, d, k), T + 2 + D + k}; beat_q.push_back(eb);
      end
      if (n < 3)       er = '{ABORT, 4'h0, T + 2 + D + n};
      else if (R >= 4) er = '{TMO, 4'h0, T + 9 + D};
      else             er = '{OK, (tgt == 2) ? 4'h0 : od, T + 6 + D + R};
      rsp_q.push_back(er);
    end
    cmd_valid = 1; cmd_target = tgt; cmd_data = d; cmd_beats = b;
    set_rdy(3, 0);
    tick();
    cmd_valid = 0; cmd_target = 2'($urandom); cmd_data = 4'($urandom); cmd_beats = 2'($urandom);
    if (tgt != 3) begin
      for (int i = 0; i <= ((D > 15) ? 15 : D); i++) begin
        set_rdy(tgt, i >= D);
        out_valid = 1'($urandom_range(0, 1)); out_data = 4'($urandom);
        tick();
      end
      if (D < 16) begin
        for (int k = 0; k < n; k++) begin
          set_rdy(3, 0);
          out_valid = 1'($urandom_range(0, 1)); out_data = 4'($urandom);
          tick();
        end
        if (n == 3) begin
          for (int j = 0; j <= ((R > 3) ? 3 : R); j++) begin
            out_valid = (j >= R);
            out_data  = (j >= R) ? od : 4'($urandom);
            tick();
          end
        end
      end
    end
    out_valid = 0;
    for (int h = 0; h < hold; h++) tick();
    rsp_ready = 1; tick(); rsp_ready = 0;
  endtask

  initial begin
    int cov_b, D, r;
    logic [1:0] tgt;
    repeat (3) @(posedge clock);
    #1 reset = 0; meta_reset = 0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {sdram_valid, flash_valid, rom_valid, rsp_valid}, 0);
    chk("rst_data", {sdram_data_o, flash_data_o, rom_data_o, rsp_data, rsp_status}, 0);
    chk("rst_coverage", coverage, 0);
    mon_en = 1;

    run_txn(0, 4'hB, 3, 0, 0, 4'hB, 0);   // latency example
    run_txn(1, 4'h6, 2, 0, 0, 4'h0, 0);   // FLASH two beats -> ABORT
    run_txn(2, 4'h5, 0, 0, 0, 4'hF, 0);   // ROM 0 -> 3 beats, data 0
    run_txn(3, 4'h9, 3, 0, 0, 4'h0, 1);   // reserved target
    run_txn(0, 4'h7, 3, 16, 0, 4'h0, 0);  // ready never arrives
    run_txn(0, 4'hA, 3, 15, 3, 4'h3, 0);  // ready and out_valid on their last chance
    run_txn(1, 4'hC, 3, 1, 4, 4'h2, 0);   // response timeout
    run_txn(1, 4'h9, 3, 1, 2, 4'h9, 5);   // rsp_ready held low

    // Reset in the middle of a burst
    mon_en = 0;
    tick();
    cov_b = coverage;
    cmd_valid = 1; cmd_target = 0; cmd_data = 4'h3; cmd_beats = 3; sdram_ready = 1;
    tick();
    cmd_valid = 0;
    tick();
    chk("beat_before_reset", sdram_valid, 1);
    reset = 1; tick(); reset = 0;
    chk("reset_drops_valid", sdram_valid, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_keeps_cov", (coverage >= cov_b) && (coverage != 0), 1);
    beat_q.delete(); rsp_q.delete();
    tick();
    mon_en = 1;

    meta_reset = 1; tick(); meta_reset = 0;
    chk("meta_reset_cov", coverage, 0);
    run_txn(0, 4'h4, 3, 0, 1, 4'h4, 0);
    chk("cov_after_txn", coverage >= 5, 1);

    for (int t = 0; t < 50; t++) begin
      tgt = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      D = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(15, 16) : $urandom_range(4, 8);
      run_txn(tgt, 4'($urandom), 2'($urandom), D, $urandom_range(0, 5), 4'($urandom),
              $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    chk("beat_q_empty", beat_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
